// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_ctrl
// Brief    : Tile sequencer for an N x N output-stationary systolic MAC array:
//            clear, skewed operand feed, drain, then row-by-row result release.
// Revision : 1.0
// ============================================================================
module systolic_array_ctrl #(
    parameter int N     = 4,
    parameter int K_MAX = 256,
    parameter int IDX_W = $clog2(K_MAX)
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [IDX_W:0]                          k_len,
    input  logic                                    abort,
    output logic                                    busy,
    output logic                                    err,
    output logic                                    acc_clr,
    output logic                                    acc_en,
    output logic [N-1:0]                            feed_en,
    output logic [N*IDX_W-1:0]                      feed_idx,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]    out_row,
    output logic                                    done
);

    localparam int c_T_W   = $clog2(K_MAX + 2*N - 1);
    localparam int c_ROW_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W:0]     c_K_MAX    = (IDX_W+1)'(K_MAX);
    localparam logic [c_T_W-1:0]   c_N        = c_T_W'(N);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(N-1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLEAR  = 3'd1;
    localparam logic [2:0] c_FEED   = 3'd2;
    localparam logic [2:0] c_DRAIN  = 3'd3;
    localparam logic [2:0] c_OUTPUT = 3'd4;
    localparam logic [2:0] c_DONE   = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [IDX_W:0]     r_k;
    logic [c_T_W-1:0]   r_t;
    logic [c_ROW_W-1:0] r_row;
    logic               r_err;

    logic               w_k_legal;
    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_xfer;
    logic               w_compute;
    logic [c_T_W-1:0]   w_k_t;
    logic [c_T_W-1:0]   w_feed_last;
    logic [c_T_W-1:0]   w_drain_last;
    logic [N-1:0]       w_lane_en;
    logic [N*IDX_W-1:0] w_lane_idx;

    assign w_k_legal    = (k_len != '0) && (k_len <= c_K_MAX);
    assign w_start_ok   = (r_state == c_IDLE) && start && w_k_legal;
    assign w_start_bad  = (r_state == c_IDLE) && start && !w_k_legal;
    assign w_xfer       = (r_state == c_OUTPUT) && out_ready && !abort;
    assign w_compute    = (r_state == c_FEED) || (r_state == c_DRAIN);
    assign w_k_t        = c_T_W'(r_k);
    // t runs continuously across FEED and DRAIN; modular arithmetic keeps N=1 correct
    assign w_feed_last  = w_k_t + c_N - c_T_W'(2);
    assign w_drain_last = w_k_t + c_N + c_N - c_T_W'(3);

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [c_T_W-1:0] c_I = c_T_W'(i);
        assign w_lane_en[i] = (r_t >= c_I) && (r_t < w_k_t + c_I);
        assign w_lane_idx[i*IDX_W +: IDX_W] = w_lane_en[i] ? IDX_W'(r_t - c_I) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_start_ok) w_next = c_CLEAR;
            c_CLEAR:  w_next = abort ? c_IDLE : c_FEED;
            c_FEED: begin
                if (abort)                    w_next = c_IDLE;
                else if (r_t == w_feed_last)  w_next = (N > 1) ? c_DRAIN : c_OUTPUT;
            end
            c_DRAIN: begin
                if (abort)                    w_next = c_IDLE;
                else if (r_t == w_drain_last) w_next = c_OUTPUT;
            end
            c_OUTPUT: begin
                if (abort)                                   w_next = c_IDLE;
                else if (out_ready && (r_row == c_LAST_ROW)) w_next = c_DONE;
            end
            c_DONE:   w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_t   <= '0;
            r_row <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_start_bad;
            if (w_start_ok) begin
                r_k <= k_len;
            end
            if (w_compute && ((w_next == c_FEED) || (w_next == c_DRAIN))) begin
                r_t <= r_t + c_T_W'(1);
            end else begin
                r_t <= '0;
            end
            if (w_xfer) begin
                r_row <= (r_row == c_LAST_ROW) ? '0 : r_row + c_ROW_W'(1);
            end else if (r_state != c_OUTPUT) begin
                r_row <= '0;
            end
        end
    end

    always_comb begin
        busy      = (r_state != c_IDLE);
        err       = r_err;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        feed_en   = '0;
        feed_idx  = '0;
        out_valid = 1'b0;
        out_row   = '0;
        done      = 1'b0;
        case (r_state)
            c_CLEAR:  acc_clr = 1'b1;
            c_FEED: begin
                acc_en   = 1'b1;
                feed_en  = w_lane_en;
                feed_idx = w_lane_idx;
            end
            c_DRAIN:  acc_en = 1'b1;
            c_OUTPUT: begin
                out_valid = 1'b1;
                out_row   = r_row;
            end
            c_DONE:   done = 1'b1;
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// Scoreboarded bench for systolic_array_ctrl: queued expectations from a
// matrix-level model and a behavioural PE array, checked by a negedge monitor.
module tb_systolic_array_ctrl;

    localparam int N     = 4;
    localparam int K_MAX = 256;
    localparam int IDX_W = 8;
    localparam int ROW_W = 2;
    localparam int BIG   = 1 << 20;

    logic               clk, rst_n, start, abort, out_ready;
    logic [IDX_W:0]     k_len;
    logic               busy, err, acc_clr, acc_en, out_valid, done;
    logic [N-1:0]       feed_en;
    logic [N*IDX_W-1:0] feed_idx;
    logic [ROW_W-1:0]   out_row;

    systolic_array_ctrl #(.N(N), .K_MAX(K_MAX), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
        .busy(busy), .err(err), .acc_clr(acc_clr), .acc_en(acc_en),
        .feed_en(feed_en), .feed_idx(feed_idx), .out_valid(out_valid),
        .out_ready(out_ready), .out_row(out_row), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int done_seen = 0, done_exp = 0;
    int err_seen  = 0, err_exp  = 0;
    bit rdy_mode = 0;

    logic [N-1:0]       q_fen[$];
    logic [N*IDX_W-1:0] q_fidx[$];
    int                 q_row[$];
    int                 q_c[$];
    int                 q_lat[$];

    int A[N][K_MAX];
    int W[K_MAX][N];
    int ps[N][N], ar[N][N], wr[N][N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        n_checks++;
        n_err++;
        $display("FAIL %s: unexpected event at %0t", nm, $time);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gen_mats(input int k);
        for (int i = 0; i < N; i++)
            for (int kk = 0; kk < k; kk++) begin
                A[i][kk] = $urandom_range(0, 255);
                W[kk][i] = $urandom_range(0, 255);
            end
    endtask

    // Expected compute window from the skew rule, result rows from C = A*W.
    task automatic push_tile(input int k, input int limit, input bit rows, input bit lat);
        for (int t = 0; t < k + 2*N - 2 && t < limit; t++) begin
            logic [N-1:0]       en;
            logic [N*IDX_W-1:0] ix;
            en = '0;
            ix = '0;
            for (int i = 0; i < N; i++)
                if (t >= i && t < i + k) begin
                    en[i] = 1'b1;
                    ix[i*IDX_W +: IDX_W] = IDX_W'(t - i);
                end
            q_fen.push_back(en);
            q_fidx.push_back(ix);
        end
        if (rows)
            for (int r = 0; r < N; r++) begin
                q_row.push_back(r);
                for (int c = 0; c < N; c++) begin
                    int s;
                    s = 0;
                    for (int kk = 0; kk < k; kk++) s += A[r][kk] * W[kk][c];
                    q_c.push_back(s);
                end
            end
        if (lat) q_lat.push_back(k + 2*N - 1);
    endtask

    task automatic issue_start(input int k);
        start = 1'b1;
        k_len = (IDX_W+1)'(k);
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while (done !== 1'b1 && c < budget) begin
            step(1);
            c++;
        end
        chk("done_within_budget", done, 1);
    endtask

    task automatic chk_quiet(input string nm);
        chk(nm, {busy, err, acc_clr, acc_en, out_valid, done, out_row, feed_en, feed_idx}, 0);
    endtask

    task automatic run_tile(input int k, input bit abort_idle);
        gen_mats(k);
        push_tile(k, BIG, 1, 1);
        abort = abort_idle;
        issue_start(k);
        abort = 1'b0;
        wait_done(k + 2*N + 400);
        done_exp++;
        step(1);
        chk("idle_after_done", busy, 0);
    endtask

    // Monitor: scoreboard pops plus a behavioural PE array fed by the DUT's feed interface.
    int   cyc = 0, clr_cyc = 0;
    logic prev_valid = 0, prev_ready = 0, prev_abort = 0;
    logic [ROW_W-1:0] prev_row = '0;
    int   nps[N][N], nar[N][N], nwr[N][N];

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                prev_valid = 1'b0;
            end else begin
                chk("clr_en_exclusive", acc_clr & acc_en, 0);
                if (acc_en) begin
                    if (q_fen.size() == 0) fail("feed_extra_cycle");
                    else begin
                        chk("feed_en", feed_en, q_fen.pop_front());
                        chk("feed_idx", feed_idx, q_fidx.pop_front());
                    end
                end else begin
                    chk("feed_quiet", {feed_en, feed_idx}, 0);
                end
                if (acc_clr) clr_cyc = cyc;
                if (out_valid && !prev_valid) begin
                    if (q_lat.size() == 0) fail("latency_unexpected_valid");
                    else chk("latency", cyc - clr_cyc, q_lat.pop_front());
                end
                if (prev_valid && !prev_ready && !prev_abort) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_row", out_row, prev_row);
                end
                if (out_valid && out_ready && !abort) begin
                    if (q_row.size() == 0) fail("row_extra_handshake");
                    else begin
                        chk("row_idx", out_row, q_row.pop_front());
                        for (int c = 0; c < N; c++)
                            chk("row_data", ps[out_row][c], q_c.pop_front());
                    end
                end
                if (done) done_seen++;
                if (err)  err_seen++;
                prev_valid = out_valid;
                prev_ready = out_ready;
                prev_abort = abort;
                prev_row   = out_row;

                if (acc_clr) begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) begin
                            ps[i][j] = 0; ar[i][j] = 0; wr[i][j] = 0;
                        end
                end else if (acc_en) begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) begin
                            int a_in, w_in;
                            if (j == 0) a_in = feed_en[i] ? A[i][feed_idx[i*IDX_W +: IDX_W]] : 0;
                            else        a_in = ar[i][j-1];
                            if (i == 0) w_in = feed_en[j] ? W[feed_idx[j*IDX_W +: IDX_W]][j] : 0;
                            else        w_in = wr[i-1][j];
                            nps[i][j] = ps[i][j] + a_in * w_in;
                            nar[i][j] = a_in;
                            nwr[i][j] = w_in;
                        end
                    ps = nps; ar = nar; wr = nwr;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) out_ready = ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b1; k_len = '0;
        #2;
        chk_quiet("reset_outputs");
        chk("reset_busy", busy, 0);
        step(2);
        rst_n = 1'b1;
        step(1);

        // Basic tile, K=3, always ready
        run_tile(3, 0);

        // Backpressure at row 1 for five cycles
        gen_mats(3);
        push_tile(3, BIG, 1, 1);
        issue_start(3);
        step(11);
        out_ready = 1'b0;
        step(5);
        out_ready = 1'b1;
        wait_done(40);
        done_exp++;
        step(1);
        chk("idle_after_bp", busy, 0);

        // Illegal lengths, then the maximum length
        issue_start(0);
        chk("err_k0", err, 1);
        chk("busy_k0", busy, 0);
        step(1);
        chk("err_k0_pulse", err, 0);
        issue_start(K_MAX + 1);
        chk("err_kbig", err, 1);
        chk("busy_kbig", busy, 0);
        err_exp += 2;
        step(1);
        run_tile(K_MAX, 0);

        // Abort during FEED t=2
        gen_mats(5);
        push_tile(5, 3, 0, 0);
        issue_start(5);
        step(3);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk_quiet("abort_feed_quiet");

        // Abort coincident with the first row handshake
        out_ready = 1'b0;
        gen_mats(2);
        push_tile(2, BIG, 0, 1);
        issue_start(2);
        step(9);
        out_ready = 1'b1;
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk_quiet("abort_output_quiet");
        run_tile(4, 1);

        // Asynchronous reset in the second DRAIN cycle
        gen_mats(2);
        push_tile(2, 6, 0, 0);
        issue_start(2);
        step(7);
        #1 rst_n = 1'b0;
        #1 chk_quiet("async_reset_quiet");
        step(1);
        rst_n = 1'b1;
        step(1);
        run_tile(1, 0);

        // start held through a whole tile re-launches right after DONE
        gen_mats(3);
        push_tile(3, BIG, 1, 1);
        start = 1'b1;
        k_len = (IDX_W+1)'(3);
        step(1);
        wait_done(60);
        gen_mats(3);
        push_tile(3, BIG, 1, 1);
        step(1);
        chk("held_idle_busy", busy, 0);
        chk("held_idle_err", err, 0);
        step(1);
        chk("held_restart_clr", acc_clr, 1);
        start = 1'b0;
        wait_done(60);
        done_exp += 2;
        step(1);
        chk("idle_after_held", busy, 0);

        // Randomized tiles with random backpressure
        rdy_mode = 1;
        for (int n = 0; n < 8; n++) begin
            step($urandom_range(0, 3));
            run_tile($urandom_range(1, 12), 0);
        end
        rdy_mode = 0;
        out_ready = 1'b1;
        step(3);

        chk("feed_queue_drained", q_fen.size(), 0);
        chk("row_queue_drained", q_row.size(), 0);
        chk("lat_queue_drained", q_lat.size(), 0);
        chk("done_count", done_seen, done_exp);
        chk("err_count", err_seen, err_exp);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencer for an N x N output-stationary array of systolic multiply-accumulate PEs.
- Each PE registers psum_out <= psum_in + a*w and forwards its activation right and its weight down.
- This block runs one tile at a time:
  - clears the accumulators;
  - drives skewed per-lane feed enables and operand-buffer indices for K inner-dimension steps;
  - waits for the wavefront to drain;
  - releases the N result rows through a valid/ready handshake.
- It sits between the tile command source and the operand buffers, array and result writer.

Parameters:
N, 4, array dimension (rows = columns = N lanes).
K_MAX, 256, maximum inner dimension per tile.
IDX_W, $clog2(K_MAX), width of one lane's operand index.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a tile; sampled only in IDLE
k_len  in  IDX_W+1  inner dimension K for this tile; legal range 1..K_MAX
abort  in  1  synchronous abandon of the current tile
busy  out  1  high in every state except IDLE
err  out  1  one-cycle pulse when start is rejected
acc_clr  out  1  one-cycle accumulator clear to the array
acc_en  out  1  array psum/forward registers update when high
feed_en  out  N  lane i valid: activation row i and weight column i
feed_idx  out  N*IDX_W  lane i operand index, slice [i*IDX_W +: IDX_W]
out_valid  out  1  result row available
out_ready  in  1  result writer accepts the row
out_row  out  $clog2(N)  index of the row being presented
done  out  1  one-cycle pulse when the tile completes

Behaviour:
- Reset (asynchronous, any state): state = IDLE, all counters = 0, every output = 0.
- States: IDLE, CLEAR, FEED, DRAIN, OUTPUT, DONE.
- IDLE:
  - On start with 1 <= k_len <= K_MAX: latch K, go to CLEAR.
  - On start with k_len == 0 or k_len > K_MAX: err = 1 for one cycle, stay in IDLE, K is not latched.
  - start outside IDLE is ignored; no err.
- CLEAR (1 cycle): acc_clr = 1, acc_en = 0. Then FEED with t = 0.
- FEED:
  - Lasts K+N-1 cycles, t = 0..K+N-2; acc_en = 1.
  - Lane i: feed_en[i] = 1 iff i <= t <= i+K-1; feed_idx lane i = t-i when enabled, else 0.
  - The datapath drives zero operands on disabled lanes, so extra MACs add 0.
- DRAIN:
  - N-1 cycles, acc_en = 1, feed_en = 0, feed_idx = 0.
  - Total compute window FEED+DRAIN = K+2N-2 cycles, which covers the last MAC at PE(N-1,N-1) (feed cycle K+2N-3) plus its register stage.
  - N = 1: DRAIN is skipped.
- OUTPUT:
  - acc_en = 0, so array contents are frozen.
  - out_valid = 1 with out_row = r, starting at r = 0.
  - A row transfers on the cycle where out_valid && out_ready; r then increments.
  - After row N-1 transfers, go to DONE.
  - out_valid stays high and out_row stays stable while out_ready is low (no timeout).
- DONE (1 cycle): done = 1, busy = 1. Then IDLE; a start in the following cycle is accepted.
- Latency: start sampled in IDLE at cycle 0; out_valid first high at cycle 1+K+2N-2 (= 10 for N=4, K=3).
- abort:
  - In CLEAR, FEED, DRAIN or OUTPUT: the next state is IDLE; all outputs return to 0 next cycle; no done.
  - abort has priority over a simultaneous out_ready handshake; that row does not count as transferred.
  - abort is ignored in IDLE and DONE.
- Counters:
  - t is wide enough for K_MAX+2N-2; no wrap within a tile.
  - K = K_MAX must give a max feed_idx of K_MAX-1 with no overflow.
- busy = 1 from CLEAR through DONE inclusive.
- acc_clr and acc_en are never both 1.

Test Plan:
1. N=4, k_len=3, out_ready=1: CLEAR 1 cycle; FEED 6 cycles with feed_en = 0001, 0011, 0111, 1110, 1100, 1000; lane 2 idx = 0,1,2 in FEED cycles 2..4; DRAIN 3 cycles; out_valid at cycle 10; out_row 0..3 on consecutive cycles; done pulse one cycle after row 3; busy low the cycle after that. Full datapath run with the PE array gives C = A*W for 4x3 by 3x4 integer matrices.
2. Backpressure: out_ready low for 5 cycles at out_row=1, then high → out_valid and out_row hold at 1; rows 1..3 transfer afterwards; exactly 4 handshakes and a single done.
3. Illegal start: k_len=0, then k_len=K_MAX+1 → err pulses each time, busy stays 0; next start with k_len=K_MAX runs, FEED lasts K_MAX+3 cycles, lane 0 max idx = 255.
4. Abort: assert abort in FEED t=2 → IDLE next cycle, all outputs 0, no done. Repeat with abort coincident with a row handshake in OUTPUT → no done, row not counted. A new tile then completes normally.
5. Reset mid-DRAIN: drop rst_n asynchronously → all outputs 0 immediately. After release, start with k_len=1 → FEED lasts N cycles, one-hot feed_en walks lane 0 to lane 3.
6. start held high continuously through a tile → ignored while busy; a new tile starts exactly in the cycle after DONE (IDLE sample), with no err.
